// File: rtl/wb_trace_pkg.sv
// Shared types and widths for the writeback trace buffer.
// WB_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to every trace entry.
package wb_trace_pkg;

    localparam int TS_W   = 16;
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        FROZEN  = 2'b10
    } state_e;

    function automatic int entry_w(input int pc_w, input int reg_w, input int data_w);
`ifdef WB_TRACE_TIMESTAMP_EN
        return TS_W + pc_w + reg_w + data_w;
`else
        return pc_w + reg_w + data_w;
`endif
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through FIFO; force_drop_head lets the owner discard the
// oldest entry so a push into a full FIFO can overwrite it.
module wb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             force_drop_head,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [PTR_W:0]   count,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             adv;

    always_comb begin
        adv      = pop | force_drop_head;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(adv);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(adv);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset)
            mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;
    assign full     = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback monitor: trace FIFO of register writes plus a shadow register file.
// Define WB_TRACE_TIMESTAMP_EN to prepend a 16-bit cycle stamp to each entry.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 5,
    parameter int DEPTH      = 16,
    parameter int OVERWRITE  = 0,
    localparam int EW  = entry_w(PC_W, REG_ADDR_W, DATA_W),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [PC_W-1:0]       wb_pc,
    input  logic                  arm,
    input  logic                  freeze,
    input  logic                  clear,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [EW-1:0]         rd_data,
    input  logic [REG_ADDR_W-1:0] shd_addr,
    output logic [DATA_W-1:0]     shd_data,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            state,
    output logic [DROP_W-1:0]     dropped
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    state_e              state_q, state_d;
    logic [DROP_W-1:0]   dropped_q, dropped_d;
    logic [DATA_W-1:0]   shadow_q [NREGS];
    logic [DATA_W-1:0]   shadow_d [NREGS];
    logic [DATA_W-1:0]   shd_data_q, shd_data_d;
    logic [EW-1:0]       entry;
    logic                wb_event, capture, pop, push, drop_head, reject, full;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    assign ts_d  = clear ? '0 : ts_q + 1'b1;
    assign entry = {ts_q, wb_pc, wb_reg, wb_data};
    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end
`else
    assign entry = {wb_pc, wb_reg, wb_data};
`endif

    always_comb begin
        wb_event  = wb_we && (wb_reg != '0);
        capture   = (state_q == CAPTURE) && !clear && wb_event;
        pop       = rd_valid && rd_ready && !clear;
        // A full FIFO accepts a push only if the head leaves the same cycle,
        // either by a consumer pop or, in circular mode, by being dropped.
        push      = capture && (!full || pop || (OVERWRITE != 0));
        drop_head = capture && full && !pop && (OVERWRITE != 0);
        reject    = capture && full && !pop && (OVERWRITE == 0);

        dropped_d = dropped_q;
        if (clear)
            dropped_d = '0;
        else if ((reject || drop_head) && (dropped_q != '1))
            dropped_d = dropped_q + 1'b1;

        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (arm && !freeze) state_d = CAPTURE;
                CAPTURE: if (freeze || reject) state_d = FROZEN;
                FROZEN:  if (arm && !freeze) state_d = CAPTURE;
                default: state_d = IDLE;
            endcase
        end

        shadow_d = shadow_q;
        if (wb_event)
            shadow_d[wb_reg] = wb_data;
        shd_data_d = shadow_q[shd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dropped_q  <= '0;
            shd_data_q <= '0;
            for (int i = 0; i < NREGS; i++)
                shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            dropped_q  <= dropped_d;
            shd_data_q <= shd_data_d;
            shadow_q   <= shadow_d;
        end
    end

    wb_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .push            (push),
        .push_data       (entry),
        .pop             (pop),
        .force_drop_head (drop_head),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .count           (count),
        .full            (full)
    );

    assign state    = state_q;
    assign dropped  = dropped_q;
    assign shd_data = shd_data_q;

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Synthesizable writeback monitor that sits beside the MIPS pipeline's MEM/WB register.
- Captures every architectural register write (PC, destination, data) into a parametrised-depth trace FIFO.
- Keeps a shadow register file of the last value written to each register.
- Replaces the bench-only print array with a hardware block that a bench or debug port can drain through a valid/ready stream, with arm/freeze control and a stop-or-overwrite mode.

Parameters:
DATA_W, 32, writeback data width
REG_ADDR_W, 5, register-number width (shadow file has 2**REG_ADDR_W entries)
PC_W, 5, PC field width
DEPTH, 16, trace FIFO entries (power of two, >=2)
OVERWRITE, 0, 0 = stop capture when full; 1 = circular, oldest entry dropped

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_we  in  1  MEM/WB register-write enable (control bit 7)
wb_reg  in  REG_ADDR_W  destination register
wb_data  in  DATA_W  value written back
wb_pc  in  PC_W  PC+4 of the retiring instruction
arm  in  1  pulse: start or resume capture
freeze  in  1  pulse: stop capture
clear  in  1  pulse: flush FIFO, zero counters (shadow file kept)
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts head
rd_data  out  PC_W+REG_ADDR_W+DATA_W (+16 with option)  {pc,reg,data}, first-word-fall-through
shd_addr  in  REG_ADDR_W  shadow read address
shd_data  out  DATA_W  shadow value, registered, 1-cycle latency
count  out  clog2(DEPTH)+1  entries held
state  out  2  00 IDLE, 01 CAPTURE, 10 FROZEN
dropped  out  16  events lost, saturating

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, count=0, rd_valid=0, dropped=0, shd_data=0, all shadow entries 0.
  - Reset mid-capture discards everything.
- Event definition: wb_we=1 and wb_reg!=0. Writes to r0 are ignored everywhere.
- Shadow file updates on every event in any state, including IDLE and FROZEN: shadow[wb_reg]<=wb_data at the clock edge.
- Shadow read-during-write to the same address returns the old value.
- FSM:
  - IDLE -arm-> CAPTURE.
  - CAPTURE -freeze-> FROZEN.
  - CAPTURE -(full and OVERWRITE=0 and event not accepted)-> FROZEN.
  - FROZEN -arm-> CAPTURE.
  - arm and freeze in the same cycle: freeze wins.
  - clear forces IDLE and has priority over arm and freeze.
- Push: only in CAPTURE, and only when the event occurs.
  - The entry is visible on rd_data the cycle after the event edge.
  - An event in the same cycle as arm is not captured.
- Pop: on a clock edge with rd_valid and rd_ready. Pop works in every state except during clear.
- Full, OVERWRITE=0:
  - A push without a simultaneous pop is rejected, increments dropped, and moves the FSM to FROZEN.
  - Push with a simultaneous pop is accepted; count is unchanged.
- Full, OVERWRITE=1:
  - Push drops the oldest entry (head advances) and increments dropped; count stays DEPTH.
  - With a simultaneous pop, the pop takes the head, the push is accepted, and dropped is unchanged.
- Events in IDLE or FROZEN are not counted as dropped.
- dropped saturates at 0xFFFF.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count = DEPTH means full.

Optional Feature:
WB_TRACE_TIMESTAMP_EN
- Defined:
  - A 16-bit free-running cycle counter (zeroed by reset and clear, wraps) is prepended to each entry.
  - rd_data = {ts,pc,reg,data}, width +16.
- Undefined: no counter, and rd_data is exactly {pc,reg,data}.

Decomposition:
- Package wb_trace_pkg holds:
  - state encodings IDLE/CAPTURE/FROZEN
  - ENTRY_W function of the parameters
  - TS_W=16
  - DROP_W=16
- One sub-module, wb_trace_fifo: parametrised FWFT FIFO with push, pop, force_drop_head, count and full outputs.
- The FSM, shadow file and counters stay in the top level.

Test Plan:
1. reset, arm, then events r1=0x00000FFF pc=1, r8=0x00001FFE pc=2 -> rd_data pops {1,1,0FFF} then {2,8,1FFE}; count 2->0; shd_addr=8 gives 0x00001FFE one cycle later.
2. Event wb_reg=0, data=0xDEADBEEF, in CAPTURE -> count stays 0; shadow[0] reads 0.
3. OVERWRITE=0, DEPTH=4, rd_ready=0, 5 events -> count=4, dropped=1, state=FROZEN; arm plus pop of one entry, then one event -> accepted, count=4.
4. OVERWRITE=1, DEPTH=4, 6 events r1..r6 -> state stays CAPTURE, dropped=2, drain yields r3,r4,r5,r6.
5. Full FIFO, push and pop in the same cycle (both modes) -> count unchanged, dropped unchanged, order preserved.
6. Assert reset with 3 entries held in CAPTURE -> next cycle state=IDLE, rd_valid=0, count=0, shadow reads 0. With WB_TRACE_TIMESTAMP_EN, events 3 cycles apart differ by ts=3.
